// File: rtl/key_pkg.sv
// key_pkg: shared types and constants for the keypad scanner.
//   KEY_W      - width of a key index (16 keys)
//   COL_INIT   - column drive after reset (column 0 active, active-low)
//   KEY_NONE   - key vector / frame image with nothing pressed
//   key_state_e- debounce FSM states
//   lowest_key - lowest-index pressed key in a 16-bit active-low image
package key_pkg;

  localparam int          KEY_W    = 4;
  localparam logic [3:0]  COL_INIT = 4'b1110;
  localparam logic [15:0] KEY_NONE = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, DEB, PRESSED, REL} key_state_e;

  typedef struct packed {
    logic             found;
    logic [KEY_W-1:0] idx;
  } key_sel_t;

  // Scan from the top down so the last hit is the lowest index, matching
  // the priority used by the downstream encoder.
  function automatic key_sel_t lowest_key(input logic [15:0] img);
    key_sel_t s;
    s.found = 1'b0;
    s.idx   = '0;
    for (int i = 15; i >= 0; i--) begin
      if (!img[i]) begin
        s.found = 1'b1;
        s.idx   = KEY_W'(i);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/key_matrix_scan_if.sv
// key_matrix_scan_if: key result bus from the scanner to the encoder.
//   DataOut   - keys 15..8, active-low one-cold
//   DataOut_0 - keys 7..0, active-low one-cold
//   KeyCode   - index of the accepted key
//   KeyValid  - one-cycle press-accepted pulse
//   KeyRel    - one-cycle release-accepted pulse
interface key_matrix_scan_if;
  logic [7:0] DataOut;
  logic [7:0] DataOut_0;
  logic [3:0] KeyCode;
  logic       KeyValid;
  logic       KeyRel;

  modport master (output DataOut, output DataOut_0, output KeyCode,
                  output KeyValid, output KeyRel);
  modport slave  (input DataOut, input DataOut_0, input KeyCode,
                  input KeyValid, input KeyRel);
endinterface

// File: rtl/key_col_scan.sv
// key_col_scan: column drive, row synchronizer and 16-bit frame image.
//   i_clk, i_rst    - clock, synchronous active-high reset
//   i_row           - raw keypad rows (active-low, asynchronous)
//   o_col           - one-cold active-low column drive
//   o_frame_img     - frame image including the sample taken this cycle
//   o_frame_done    - high on the tick that samples column 3
import key_pkg::*;

module key_col_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_row,
  output logic [3:0]  o_col,
  output logic [15:0] o_frame_img,
  output logic        o_frame_done
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0] r_div;
  logic [1:0]    r_col_idx;
  logic [3:0]    r_col;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [15:0]   r_img;
  logic          w_tick;
  logic [15:0]   w_img_nxt;

  assign w_tick = (r_div == DW'(SCAN_DIV - 1));

  // Bit index 4*r+c is just {r, c}.
  always_comb begin
    w_img_nxt = r_img;
    if (w_tick) begin
      for (int r = 0; r < 4; r++) begin
        w_img_nxt[{r[1:0], r_col_idx}] = r_sync2[r];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div     <= '0;
      r_col_idx <= '0;
      r_col     <= COL_INIT;
      r_sync1   <= 4'hF;
      r_sync2   <= 4'hF;
      r_img     <= KEY_NONE;
    end else begin
      r_sync1 <= i_row;
      r_sync2 <= r_sync1;
      r_img   <= w_img_nxt;
      if (w_tick) begin
        r_div     <= '0;
        r_col_idx <= r_col_idx + 2'd1;
        r_col     <= {r_col[2:0], r_col[3]};
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign o_col        = r_col;
  assign o_frame_img  = w_img_nxt;
  assign o_frame_done = w_tick && (r_col_idx == 2'd3);

endmodule

// File: rtl/key_matrix_scan.sv
// key_matrix_scan: 4x4 keypad scanner with frame-based debounce.
//   Clk, Rst  - clock, synchronous active-high reset
//   Row       - keypad rows, active-low, asynchronous
//   Col       - keypad column drive, one-cold active-low
//   key_bus   - key vector, key code and press/release strobes
//
//   state   | meaning
//   IDLE    | no key accepted, nothing seen
//   DEB     | candidate key seen in cnt consecutive frames
//   PRESSED | candidate accepted and still present
//   REL     | accepted key absent for cnt consecutive frames
import key_pkg::*;

module key_matrix_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int DEB_SCANS = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [3:0]       Row,
  output logic [3:0]       Col,
  key_matrix_scan_if.master key_bus
);

  localparam int CW = $clog2(DEB_SCANS + 1);

  logic [15:0]      w_frame_img;
  logic             w_frame_done;
  key_sel_t         w_sel;
  logic             w_same;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_cnt_full;

  key_state_e       r_state, w_state_nxt;
  logic [KEY_W-1:0] r_cand, w_cand_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [KEY_W-1:0] r_code, w_code_nxt;
  logic [15:0]      r_vec, w_vec_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_rel, w_rel_nxt;

  key_col_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .i_clk        (Clk),
    .i_rst        (Rst),
    .i_row        (Row),
    .o_col        (Col),
    .o_frame_img  (w_frame_img),
    .o_frame_done (w_frame_done)
  );

  assign w_sel      = lowest_key(w_frame_img);
  assign w_same     = w_sel.found && (w_sel.idx == r_cand);
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_cnt_full = (w_cnt_inc == CW'(DEB_SCANS));

  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_code_nxt  = r_code;
    w_vec_nxt   = r_vec;
    w_valid_nxt = 1'b0;
    w_rel_nxt   = 1'b0;
    if (w_frame_done) begin
      case (r_state)
        IDLE: begin
          if (w_sel.found) begin
            w_state_nxt = DEB;
            w_cand_nxt  = w_sel.idx;
            w_cnt_nxt   = CW'(1);
          end
        end
        DEB: begin
          if (!w_sel.found) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else if (w_same) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_full) begin
              w_state_nxt = PRESSED;
              w_cnt_nxt   = '0;
              w_code_nxt  = r_cand;
              w_vec_nxt   = ~(16'h1 << r_cand);
              w_valid_nxt = 1'b1;
            end
          end else begin
            w_cand_nxt = w_sel.idx;
            w_cnt_nxt  = CW'(1);
          end
        end
        PRESSED: begin
          if (!w_same) begin
            w_state_nxt = REL;
            w_cnt_nxt   = CW'(1);
          end
        end
        REL: begin
          if (w_same) begin
            w_state_nxt = PRESSED;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_full) begin
              w_state_nxt = IDLE;
              w_cnt_nxt   = '0;
              w_vec_nxt   = KEY_NONE;
              w_rel_nxt   = 1'b1;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= IDLE;
      r_cand  <= '0;
      r_cnt   <= '0;
      r_code  <= '0;
      r_vec   <= KEY_NONE;
      r_valid <= 1'b0;
      r_rel   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
      r_code  <= w_code_nxt;
      r_vec   <= w_vec_nxt;
      r_valid <= w_valid_nxt;
      r_rel   <= w_rel_nxt;
    end
  end

  assign key_bus.DataOut   = r_vec[15:8];
  assign key_bus.DataOut_0 = r_vec[7:0];
  assign key_bus.KeyCode   = r_code;
  assign key_bus.KeyValid  = r_valid;
  assign key_bus.KeyRel    = r_rel;

endmodule

// File: tb/tb_key_matrix_scan.sv
// tb_key_matrix_scan: keypad model driving Row from Col, frame-level
// reference model of the debounce rules, directed and random scenarios.
module tb_key_matrix_scan;

  localparam int SCAN_DIV  = 4;
  localparam int DEB_SCANS = 3;
  localparam int FRAME     = 4 * SCAN_DIV;

  localparam int M_IDLE = 0, M_DEB = 1, M_PRESSED = 2, M_REL = 3;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [3:0] Row;
  logic [3:0] Col;
  logic [15:0] keys;

  key_matrix_scan_if key_bus ();

  key_matrix_scan #(.SCAN_DIV(SCAN_DIV), .DEB_SCANS(DEB_SCANS)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Row     (Row),
    .Col     (Col),
    .key_bus (key_bus)
  );

  always #5 Clk = ~Clk;

  // Keypad: a pressed key shorts its row to its column.
  always_comb begin
    Row = 4'hF;
    for (int k = 0; k < 16; k++)
      if (keys[k] && !Col[k % 4]) Row[k / 4] = 1'b0;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_valid  = 0;
  int n_rel    = 0;
  int n_both   = 0;

  always @(negedge Clk) begin
    if (key_bus.KeyValid) n_valid++;
    if (key_bus.KeyRel)   n_rel++;
    if (key_bus.KeyValid && key_bus.KeyRel) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model, advanced once per frame.
  int          m_st, m_cand, m_cnt, m_code;
  logic [15:0] m_vec;
  logic        m_valid, m_rel;
  int          exp_nv = 0, exp_nr = 0;

  task automatic model_reset();
    m_st = M_IDLE; m_cand = 0; m_cnt = 0; m_code = 0;
    m_vec = 16'hFFFF; m_valid = 0; m_rel = 0;
  endtask

  task automatic model_frame(input logic [15:0] pressed);
    int k;
    k = -1;
    for (int i = 15; i >= 0; i--) if (pressed[i]) k = i;
    m_valid = 0; m_rel = 0;
    case (m_st)
      M_IDLE: if (k >= 0) begin m_st = M_DEB; m_cand = k; m_cnt = 1; end
      M_DEB: begin
        if (k < 0) m_st = M_IDLE;
        else if (k == m_cand) begin
          m_cnt++;
          if (m_cnt == DEB_SCANS) begin
            m_st = M_PRESSED; m_code = k; m_vec = ~(16'h1 << k);
            m_valid = 1; exp_nv++;
          end
        end else begin m_cand = k; m_cnt = 1; end
      end
      M_PRESSED: if (k != m_cand) begin m_st = M_REL; m_cnt = 1; end
      default: begin
        if (k == m_cand) m_st = M_PRESSED;
        else begin
          m_cnt++;
          if (m_cnt == DEB_SCANS) begin
            m_st = M_IDLE; m_vec = 16'hFFFF; m_rel = 1; exp_nr++;
          end
        end
      end
    endcase
  endtask

  task automatic run_frame(input logic [15:0] pressed);
    keys = pressed;
    repeat (FRAME) @(posedge Clk);
    #1;
    model_frame(pressed);
    chk("vec",   {key_bus.DataOut, key_bus.DataOut_0}, m_vec);
    chk("code",  key_bus.KeyCode, m_code);
    chk("valid", key_bus.KeyValid, m_valid);
    chk("rel",   key_bus.KeyRel, m_rel);
    @(negedge Clk); #1;
    chk("n_valid", n_valid, exp_nv);
    chk("n_rel",   n_rel, exp_nr);
  endtask

  task automatic do_reset(input int mid);
    repeat (mid) @(posedge Clk);
    @(negedge Clk) Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    model_reset();
    chk("rst_col", Col, 4'b1110);
    chk("rst_vec", {key_bus.DataOut, key_bus.DataOut_0}, 16'hFFFF);
    chk("rst_code", key_bus.KeyCode, 0);
    chk("rst_valid", key_bus.KeyValid, 0);
    chk("rst_rel", key_bus.KeyRel, 0);
    chk("rst_n_valid", n_valid, exp_nv);
    chk("rst_n_rel", n_rel, exp_nr);
  endtask

  logic [15:0] prev;

  initial begin
    keys = 16'h0;
    Rst  = 1'b1;
    repeat (3) @(posedge Clk);
    do_reset(0);

    // key 0 press and hold
    repeat (5) run_frame(16'h0001);
    // key 15 press, hold, release
    repeat (4) run_frame(16'h8000);
    repeat (4) run_frame(16'h0000);
    // key 6 with a one-frame bounce
    repeat (2) run_frame(16'h0040);
    run_frame(16'h0000);
    repeat (4) run_frame(16'h0040);
    repeat (3) run_frame(16'h0000);
    // keys 5 and 9 together, then add key 2 while held
    repeat (4) run_frame(16'h0220);
    repeat (3) run_frame(16'h0224);
    repeat (3) run_frame(16'h0000);
    // key 10 drops out one frame during release
    repeat (4) run_frame(16'h0400);
    run_frame(16'h0000);
    repeat (3) run_frame(16'h0400);
    repeat (3) run_frame(16'h0000);
    // reset while debouncing key 3
    repeat (2) run_frame(16'h0008);
    do_reset(7);
    repeat (4) run_frame(16'h0008);
    // reset while pressed: no KeyRel, vector cleared
    do_reset(5);
    run_frame(16'h0000);

    // random stimulus
    prev = 16'h0;
    for (int it = 0; it < 120; it++) begin
      int sel;
      logic [15:0] nk;
      sel = $urandom_range(0, 9);
      if (sel <= 4)      nk = prev;
      else if (sel <= 6) nk = 16'h0;
      else if (sel <= 8) nk = 16'h1 << $urandom_range(0, 15);
      else               nk = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) do_reset($urandom_range(1, 12));
      run_frame(nk);
      prev = nk;
    end

    chk("no_overlap", n_both, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
